// File: rtl/grey_decode.sv
// Receive-side decoder for the 5-bit one-change decade code: synchronises the
// ripple-clocked counter bus, waits for a stable plateau, decodes to packed BCD.
module grey_decode #(
   parameter int pDIGITS = 2,
   parameter int pSTABLE = 4,
   parameter int pERRW   = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [5*pDIGITS-1:0]   i_grey,
   input  logic                   i_clr,
   output logic [4*pDIGITS-1:0]   o_bcd,
   output logic                   o_valid,
   output logic                   o_step,
   output logic                   o_wrap,
   output logic                   o_err,
   output logic [pERRW-1:0]       o_err_cnt
);

   localparam int               CW         = $clog2(pSTABLE + 1);
   localparam logic [CW-1:0]    STABLE_MAX = CW'(pSTABLE);
   localparam logic [CW-1:0]    STABLE_M1  = CW'(pSTABLE - 1);
   localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
   localparam logic [pERRW-1:0] ERR_MAX    = {pERRW{1'b1}};
   localparam logic [pERRW-1:0] ERR_ONE    = pERRW'(1);

   logic [5*pDIGITS-1:0] r_s1, r_s2, r_s3;
   logic [CW-1:0]        cnt;
   logic                 accept;

   logic [4*pDIGITS-1:0] cand_bcd;
   logic [4*pDIGITS-1:0] inc_bcd;
   logic                 cand_ok;
   logic                 carry;
   logic [4:0]           dec;
   logic                 take_evt;
   logic                 step_evt;
   logic                 err_evt;

   // Returns {legal, value} for one digit code.
   function automatic logic [4:0] decode_digit(input logic [4:0] code);
      case (code)
         5'b11000: return {1'b1, 4'd0};
         5'b11001: return {1'b1, 4'd1};
         5'b10001: return {1'b1, 4'd2};
         5'b10011: return {1'b1, 4'd3};
         5'b00011: return {1'b1, 4'd4};
         5'b00111: return {1'b1, 4'd5};
         5'b00110: return {1'b1, 4'd6};
         5'b01110: return {1'b1, 4'd7};
         5'b01100: return {1'b1, 4'd8};
         5'b11100: return {1'b1, 4'd9};
         default:  return 5'b0_0000;
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= i_grey;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (r_s2 != r_s3) begin
         cnt <= '0;
      end else if (cnt != STABLE_MAX) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // Fires once per plateau: the count passes pSTABLE-1 only on its way up.
   assign accept = (r_s2 == r_s3) && (cnt == STABLE_M1);

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      cand_bcd = '0;
      inc_bcd  = '0;
      cand_ok  = 1'b1;
      carry    = 1'b1;
      dec      = '0;
      for (int i = 0; i < pDIGITS; i++) begin
         dec                  = decode_digit(r_s2[5*i +: 5]);
         cand_bcd[4*i +: 4]   = dec[3:0];
         cand_ok              = cand_ok & dec[4];
         if (!carry) begin
            inc_bcd[4*i +: 4] = o_bcd[4*i +: 4];
         end else if (o_bcd[4*i +: 4] == 4'd9) begin
            inc_bcd[4*i +: 4] = 4'd0;
         end else begin
            inc_bcd[4*i +: 4] = o_bcd[4*i +: 4] + 4'd1;
            carry             = 1'b0;
         end
      end
   end

   // A carry out of the top digit means o_bcd was all 9s.
   always_comb begin
      take_evt = 1'b0;
      step_evt = 1'b0;
      err_evt  = 1'b0;
      if (accept) begin
         if (!cand_ok) begin
            err_evt  = 1'b1;
         end else if (!o_valid) begin
            take_evt = 1'b1;
         end else if (cand_bcd != o_bcd) begin
            take_evt = 1'b1;
            step_evt = (cand_bcd == inc_bcd);
            err_evt  = (cand_bcd != inc_bcd);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_bcd   <= '0;
         o_valid <= 1'b0;
         o_step  <= 1'b0;
         o_wrap  <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         o_step <= step_evt;
         o_wrap <= step_evt & carry;
         o_err  <= err_evt;
         if (take_evt) begin
            o_bcd   <= cand_bcd;
            o_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_err_cnt <= '0;
      end else if (i_clr) begin
         o_err_cnt <= '0;
      end else if (err_evt && (o_err_cnt != ERR_MAX)) begin
         o_err_cnt <= o_err_cnt + ERR_ONE;
      end
   end

endmodule
